mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers. It is the next-generation execution resource for the single-cycle MIPS core.
- Adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support to the datapath, which until now had only a combinational ALU, shifter and zero-fill path.
- Sits beside the ALU and is driven by decoder/ALU_Ctrl. It stalls PC/instruction fetch via busy_o, and its HI/LO outputs feed the write-back mux for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; the product is 2*WIDTH bits.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start_i  input  1  launch the operation selected by op_i; sampled on a clock edge.
- op_i  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- src1_i  input  WIDTH  multiplicand / dividend (rs).
- src2_i  input  WIDTH  multiplier / divisor (rt).
- write_hi_i  input  1  MTHI: HI <= wdata_i.
- write_lo_i  input  1  MTLO: LO <= wdata_i.
- wdata_i  input  WIDTH  MTHI/MTLO data.
- flush_i  input  1  abort the in-flight operation.
- busy_o  output  1  operation in flight.
- done_o  output  1  one-cycle pulse when HI/LO are updated by an operation.
- div_zero_o  output  1  sticky flag: last completed divide had divisor 0; cleared on the next start.
- hi_o  output  WIDTH  HI register.
- lo_o  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state IDLE; hi_o=0, lo_o=0, busy_o=0, done_o=0, div_zero_o=0; internal counter and accumulators cleared.
- States:
  - IDLE -> RUN on start_i=1.
  - RUN holds for exactly WIDTH cycles (counter WIDTH-1 down to 0), then -> FIX.
  - FIX -> IDLE unconditionally after one cycle.
- Start edge k:
  - Operands are latched as magnitudes (two's-complement negate if signed op and MSB=1). The result signs are latched.
  - busy_o=1 from after edge k through the FIX cycle.
  - HI/LO are written at edge k+WIDTH+1. At the same edge busy_o falls and done_o rises for one cycle.
  - Fixed latency is WIDTH+1 cycles for every op, including divide-by-zero.
- Multiply: shift-add, one multiplier bit per RUN cycle, 2*WIDTH-bit accumulator.
  - Signed: product is negated in FIX if operand signs differ.
  - {HI,LO} = product.
- Divide: restoring, one quotient bit per RUN cycle.
  - LO = quotient, HI = remainder.
  - Signed: quotient is negated if signs differ; remainder takes the sign of the dividend.
  - MIN/-1 yields LO=MIN, HI=0, with no exception.
- Divide by zero: HI=dividend (raw src1), LO=all ones, div_zero_o=1.
- start_i while busy_o=1 is ignored: no restart and no queueing. The issuing logic must stall.
- MTHI/MTLO:
  - Honoured only in IDLE, and only on cycles without a same-cycle completion.
  - Writes while busy_o=1 are dropped.
  - MTHI/MTLO and start_i in the same IDLE cycle: the write lands at that edge, then the operation later overwrites both HI and LO.
- flush_i=1:
  - In RUN or FIX: -> IDLE at the next edge; HI/LO are not updated; done_o stays 0; busy_o falls.
  - flush_i takes priority over completion in FIX.
  - In IDLE, flush_i also suppresses a same-cycle start_i.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (alongside the existing decoder/ALU_Ctrl constants):
  - Op encodings OP_MULTU=2'b00, OP_MULT=2'b01, OP_DIVU=2'b10, OP_DIV=2'b11.
  - State encodings IDLE/RUN/FIX.
  - Counter width as $clog2(WIDTH).
- Sub-module: mul_div_step, a combinational single iteration (add-shift or subtract-compare-shift, selected by op bit 1) on the WIDTH-bit partial registers. The top holds the FSM, counter, sign fix-up and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done_o at start+33 cycles; HI=0xFFFFFFFE, LO=0x00000001; busy_o high for 33 cycles.
- MULT -7*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7/2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU 100/0 -> HI=0x00000064, LO=0xFFFFFFFF, div_zero_o=1; a following DIVU 100/7 clears the flag and gives LO=14, HI=2.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; MULTU 0x12345678*0 -> HI=0, LO=0.
- MTLO 0xABCD in IDLE -> lo_o=0xABCD next cycle; MTHI during busy -> HI unchanged; start_i during busy -> ignored, and only the first result lands.
- flush_i at RUN cycle 10 -> busy_o falls next cycle, no done_o, HI/LO keep prior values; rst_n low mid-RUN -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared multiply/divide definitions: op and state encodings, counter sizing, per-op control.
// Latency and backpressure: not applicable (declarations only).
package mul_div_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } state_e;

   localparam int DEF_WIDTH = 32;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

   // Control captured when an operation is accepted.
   typedef struct packed {
      logic is_div;
      logic neg_q;
      logic neg_r;
      logic div_zero;
   } op_ctl_t;

endpackage

// File: rtl/mul_div_step.sv
// One combinational iteration: shift-add for multiply or restoring subtract-shift for divide.
// Latency 0 cycles; no backpressure (pure function of its inputs).
module mul_div_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem_sh;

   always_comb begin
      hi_o   = hi_i;
      lo_o   = lo_i;
      sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
      rem_sh = {hi_i, lo_i[WIDTH-1]};
      if (is_div) begin
         // Remainder stays below the divisor, so the difference fits in WIDTH bits.
         if (rem_sh >= {1'b0, opnd_i}) begin
            hi_o = rem_sh[WIDTH-1:0] - opnd_i;
            lo_o = {lo_i[WIDTH-2:0], 1'b1};
         end else begin
            hi_o = rem_sh[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_o = sum[WIDTH:1];
         lo_o = {sum[0], lo_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO and MTHI/MTLO writes.
// Latency WIDTH+1 cycles for every op; start_i while busy_o is dropped, issuer must stall.
module mul_div_unit
   import mul_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic             write_hi_i,
   input  logic             write_lo_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q, raw_src1_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   op_ctl_t          ctl_q;
   logic             done_q, dz_q;
   logic             accept, step_en, complete;

   logic             s1_neg, s2_neg;
   logic [WIDTH-1:0] mag1, mag2;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix, res_hi, res_lo;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      step_en  = 1'b0;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i && !flush_i) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               step_en = 1'b1;
               if (cnt_q == '0) state_d = FIX;
            end
         end
         FIX: begin
            state_d  = IDLE;
            complete = !flush_i;
         end
         default: state_d = IDLE;
      endcase
   end

   assign s1_neg = op_i[0] & src1_i[WIDTH-1];
   assign s2_neg = op_i[0] & src2_i[WIDTH-1];
   assign mag1   = s1_neg ? -src1_i : src1_i;
   assign mag2   = s2_neg ? -src2_i : src2_i;

   mul_div_step #(.WIDTH(WIDTH)) u_step (
      .is_div (ctl_q.is_div),
      .hi_i   (acc_hi_q),
      .lo_i   (acc_lo_q),
      .opnd_i (opnd_q),
      .hi_o   (step_hi),
      .lo_o   (step_lo)
   );

   // Sign fix-up and divide-by-zero override applied in the FIX cycle.
   always_comb begin
      prod     = {acc_hi_q, acc_lo_q};
      prod_fix = ctl_q.neg_q ? -prod : prod;
      quo_fix  = ctl_q.neg_q ? -acc_lo_q : acc_lo_q;
      rem_fix  = ctl_q.neg_r ? -acc_hi_q : acc_hi_q;
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = prod_fix[WIDTH-1:0];
      if (ctl_q.is_div) begin
         if (ctl_q.div_zero) begin
            res_hi = raw_src1_q;
            res_lo = '1;
         end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         opnd_q     <= '0;
         raw_src1_q <= '0;
         ctl_q      <= '0;
      end else if (accept) begin
         cnt_q          <= CW'(WIDTH - 1);
         acc_hi_q       <= '0;
         acc_lo_q       <= op_i[1] ? mag1 : mag2;
         opnd_q         <= op_i[1] ? mag2 : mag1;
         raw_src1_q     <= src1_i;
         ctl_q.is_div   <= op_i[1];
         ctl_q.neg_q    <= s1_neg ^ s2_neg;
         ctl_q.neg_r    <= s1_neg;
         ctl_q.div_zero <= op_i[1] && (src2_i == '0);
      end else if (step_en) begin
         cnt_q    <= cnt_q - CW'(1);
         acc_hi_q <= step_hi;
         acc_lo_q <= step_lo;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         done_q <= complete;
         if (accept)        dz_q <= 1'b0;
         else if (complete) dz_q <= ctl_q.is_div & ctl_q.div_zero;
         if (complete) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end else if (state_q == IDLE) begin
            if (write_hi_i) hi_q <= wdata_i;
            if (write_lo_i) lo_q <= wdata_i;
         end
      end
   end

   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;
   assign div_zero_o = dz_q;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed test-plan vectors plus randomized ops against an arithmetic model.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src1, src2, wdata;
   logic        write_hi, write_lo, flush;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk_i      (clk),
      .rst_n      (rst_n),
      .start_i    (start),
      .op_i       (op),
      .src1_i     (src1),
      .src2_i     (src2),
      .write_hi_i (write_hi),
      .write_lo_i (write_lo),
      .wdata_i    (wdata),
      .flush_i    (flush),
      .busy_o     (busy),
      .done_o     (done),
      .div_zero_o (div_zero),
      .hi_o       (hi),
      .lo_o       (lo)
   );

   // Reference: {div_zero, hi, lo} from plain 64-bit arithmetic.
   function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      if (o[1] == 1'b0) begin
         if (o[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end else begin
            sa = longint'(a);
            sb = longint'(b);
         end
         p = sa * sb;
         return {1'b0, p};
      end
      if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      if (o[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'(a);
         sb = longint'(b);
      end
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
   endfunction

   // Launch one op and observe 40 samples; j=0 is the sample just after the start edge.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt, output int dcnt, output logic dz0);
      @(negedge clk);
      start = 1'b1; op = o; src1 = a; src2 = b;
      @(negedge clk);
      start = 1'b0;
      lat = -1; bcnt = 0; dcnt = 0; dz0 = div_zero;
      for (int j = 0; j < 40; j++) begin
         if (done) begin
            dcnt++;
            if (lat < 0) lat = j;
         end
         if (busy) bcnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
      wdata = '0; write_hi = 1'b0; write_lo = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
         bad++;
         $display("FAIL reset_outputs: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, div_zero, hi, lo);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_mtlo();
      @(negedge clk);
      write_lo = 1'b1; wdata = 32'h0000_ABCD;
      @(negedge clk);
      write_lo = 1'b0;
      total++;
      if (lo !== 32'h0000_ABCD || hi !== 32'd0) begin
         bad++;
         $display("FAIL mtlo_idle: got hi=%h lo=%h want hi=00000000 lo=0000abcd", hi, lo);
      end
   endtask

   task automatic test_directed();
      logic [1:0]  o;
      logic [31:0] a, b, eh, el;
      logic        ed, dz0;
      int lat, bcnt, dcnt;
      for (int i = 0; i < 7; i++) begin
         case (i)
            0: begin o = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; eh = 32'hFFFF_FFFE; el = 32'h0000_0001; ed = 1'b0; end
            1: begin o = 2'b01; a = 32'hFFFF_FFF9; b = 32'd3;         eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFEB; ed = 1'b0; end
            2: begin o = 2'b11; a = 32'hFFFF_FFF9; b = 32'd2;         eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFFD; ed = 1'b0; end
            3: begin o = 2'b10; a = 32'd100;       b = 32'd0;         eh = 32'h0000_0064; el = 32'hFFFF_FFFF; ed = 1'b1; end
            4: begin o = 2'b10; a = 32'd100;       b = 32'd7;         eh = 32'd2;         el = 32'd14;        ed = 1'b0; end
            5: begin o = 2'b11; a = 32'h8000_0000; b = 32'hFFFF_FFFF; eh = 32'd0;         el = 32'h8000_0000; ed = 1'b0; end
            default: begin o = 2'b00; a = 32'h1234_5678; b = 32'd0;   eh = 32'd0;         el = 32'd0;         ed = 1'b0; end
         endcase
         run_op(o, a, b, lat, bcnt, dcnt, dz0);
         total++;
         if (lat !== 33) begin
            bad++;
            $display("FAIL dir%0d_latency: got %0d want 33", i, lat);
         end
         total++;
         if (bcnt !== 33 || dcnt !== 1) begin
            bad++;
            $display("FAIL dir%0d_busy_done: got busy_cycles=%0d done_pulses=%0d want 33/1", i, bcnt, dcnt);
         end
         total++;
         if (hi !== eh || lo !== el || div_zero !== ed) begin
            bad++;
            $display("FAIL dir%0d_result: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b", i, hi, lo, div_zero, eh, el, ed);
         end
         total++;
         if (dz0 !== 1'b0) begin
            bad++;
            $display("FAIL dir%0d_dz_clear_on_start: got %b want 0", i, dz0);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0]  o;
      logic [31:0] a, b;
      logic [64:0] exp_v;
      logic        dz0;
      int lat, bcnt, dcnt, kind;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         kind = $urandom_range(0, 7);
         if (kind == 0) b = 32'd0;
         if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if (kind == 2) b = 32'($urandom_range(1, 20));
         exp_v = ref_op(o, a, b);
         run_op(o, a, b, lat, bcnt, dcnt, dz0);
         total++;
         if (lat !== 33 || dcnt !== 1) begin
            bad++;
            $display("FAIL rnd%0d_timing: got lat=%0d pulses=%0d want 33/1", i, lat, dcnt);
         end
         total++;
         if ({div_zero, hi, lo} !== exp_v) begin
            bad++;
            $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got dz=%b hi=%h lo=%h want dz=%b hi=%h lo=%h",
                     i, o, a, b, div_zero, hi, lo, exp_v[64], exp_v[63:32], exp_v[31:0]);
         end
      end
   endtask

   task automatic test_mthi_busy();
      logic [31:0] hi_before;
      int seen;
      @(negedge clk);
      start = 1'b1; op = 2'b00; src1 = 32'd3; src2 = 32'd5;
      @(negedge clk);
      start = 1'b0;
      hi_before = hi;
      @(negedge clk);
      write_hi = 1'b1; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      write_hi = 1'b0;
      total++;
      if (hi !== hi_before) begin
         bad++;
         $display("FAIL mthi_busy_dropped: got hi=%h want %h", hi, hi_before);
      end
      seen = 0;
      for (int j = 0; j < 40 && seen == 0; j++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      total++;
      if (seen != 1 || hi !== 32'd0 || lo !== 32'd15) begin
         bad++;
         $display("FAIL mthi_busy_result: got done_seen=%0d hi=%h lo=%h want 1/00000000/0000000f", seen, hi, lo);
      end
   endtask

   task automatic test_back_to_back();
      int pulses, first;
      @(negedge clk);
      start = 1'b1; op = 2'b00; src1 = 32'd6; src2 = 32'd7;
      @(negedge clk);
      start = 1'b0;
      pulses = 0; first = -1;
      for (int j = 0; j < 70; j++) begin
         if (j == 2) begin
            start = 1'b1; op = 2'b10; src1 = 32'd100; src2 = 32'd7;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            pulses++;
            if (first < 0) first = j;
         end
         @(negedge clk);
      end
      total++;
      if (pulses !== 1 || first !== 33) begin
         bad++;
         $display("FAIL start_while_busy_ignored: got pulses=%0d first=%0d want 1/33", pulses, first);
      end
      total++;
      if (hi !== 32'd0 || lo !== 32'd42) begin
         bad++;
         $display("FAIL start_while_busy_result: got hi=%h lo=%h want 00000000/0000002a", hi, lo);
      end
   endtask

   task automatic test_mt_with_start();
      int seen;
      @(negedge clk);
      start = 1'b1; op = 2'b00; src1 = 32'd2; src2 = 32'd3;
      write_hi = 1'b1; write_lo = 1'b1; wdata = 32'h5555_5555;
      @(negedge clk);
      start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
      total++;
      if (hi !== 32'h5555_5555 || lo !== 32'h5555_5555 || busy !== 1'b1) begin
         bad++;
         $display("FAIL mt_with_start_lands: got hi=%h lo=%h busy=%b want 55555555/55555555/1", hi, lo, busy);
      end
      seen = 0;
      for (int j = 0; j < 40 && seen == 0; j++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      total++;
      if (seen != 1 || hi !== 32'd0 || lo !== 32'd6) begin
         bad++;
         $display("FAIL mt_with_start_overwrite: got done_seen=%0d hi=%h lo=%h want 1/00000000/00000006", seen, hi, lo);
      end
   endtask

   task automatic test_flush();
      logic [31:0] hi_before, lo_before;
      int pulses, f;
      for (int k = 0; k < 2; k++) begin
         f = (k == 0) ? 10 : 32;
         hi_before = hi; lo_before = lo;
         @(negedge clk);
         start = 1'b1; op = 2'b11; src1 = 32'hFFFF_0000; src2 = 32'd9;
         @(negedge clk);
         start = 1'b0;
         for (int j = 0; j < f; j++) @(negedge clk);
         flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
         total++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL flush_at_%0d_idle: got busy=%b done=%b want 0/0", f, busy, done);
         end
         pulses = 0;
         for (int j = 0; j < 40; j++) begin
            if (done) pulses++;
            @(negedge clk);
         end
         total++;
         if (pulses !== 0 || hi !== hi_before || lo !== lo_before) begin
            bad++;
            $display("FAIL flush_at_%0d_no_update: got pulses=%0d hi=%h lo=%h want 0/%h/%h", f, pulses, hi, lo, hi_before, lo_before);
         end
      end
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 2'b00; src1 = 32'd1; src2 = 32'd1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL flush_suppresses_idle_start: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      start = 1'b1; op = 2'b10; src1 = 32'd100; src2 = 32'd0;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
         bad++;
         $display("FAIL async_reset_mid_run: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, div_zero, hi, lo);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || lo !== 32'd0) begin
         bad++;
         $display("FAIL async_reset_stays_idle: got busy=%b done=%b lo=%h want 0/0/00000000", busy, done, lo);
      end
   endtask

   initial begin
      test_reset();
      test_mtlo();
      test_directed();
      test_random();
      test_mthi_busy();
      test_back_to_back();
      test_mt_with_start();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
